mmio_uart_tx: RTL



---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state encoding.
package uart_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_DIV    = 4'h8;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    // A programmed divisor of zero would stall the line, so it behaves as one.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with a combinational head output; a push into a full
// FIFO is only accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, TXDATA/STATUS/DIV
// registers, a TX FIFO and the serialising FSM with its baud counter.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd868,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr,
    output logic [31:0] rdata,
    output logic        tx
);

    uart_tx_state_e state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    div_q;
    logic [15:0]    div_m1;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;

    logic           hit;
    logic [3:0]     off;
    logic           wr_txdata, wr_status, wr_div;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status_w;
    logic           unused_bits;

    assign hit       = (addr[31:4] == BASE[31:4]);
    assign off       = {addr[3:2], 2'b00};
    assign wr_txdata = wr && hit && (off == OFF_TXDATA);
    assign wr_status = wr && hit && (off == OFF_STATUS);
    assign wr_div    = wr && hit && (off == OFF_DIV);
    assign div_m1    = eff_div(div_q) - 16'd1;
    assign tx        = tx_q;
    assign unused_bits = ^{wdata[31:16], addr[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_w                     = '0;
        status_w[ST_FULL]            = fifo_full;
        status_w[ST_EMPTY]           = fifo_empty;
        status_w[ST_BUSY]            = (state_q != IDLE);
        status_w[ST_OVF]             = ovf_q;
        status_w[ST_CNT_LSB +: 4]    = 4'(fifo_count);
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (off)
                OFF_STATUS: rdata = status_w;
                OFF_DIV:    rdata = {16'h0000, div_q};
                default:    rdata = '0;
            endcase
        end
    end

    // A dropped byte is one pushed while full with no pop freeing a slot.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && wdata[ST_OVF])
            ovf_d = 1'b0;
        else if (wr_txdata && fifo_full && !fifo_pop)
            ovf_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    tx_d     = 1'b0;
                    cnt_d    = div_m1;
                    state_d  = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    tx_d      = shreg_q[0];
                    cnt_d     = div_m1;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = div_m1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Line carries shreg_q[0]; the next bit sits one place up.
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dout;
                        tx_d     = 1'b0;
                        cnt_d    = div_m1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RESET;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            if (wr_div) div_q <= wdata[15:0];
        end
    end

endmodule
